bc_disp_scan8: RTL and testbench
================================

Name: bc_disp_scan8

Overview:
- Receiving end of the game's 8-digit display-code interface (d1..d8, 6-bit glyph codes) produced by the game FSM.
- Decodes each code to a seven-segment pattern and time-multiplexes eight common-anode digits with anti-ghosting blanking.
- Snapshots all eight codes once per scan frame, so a frame never mixes old and new content.
- Sits between the game FSM and the board's AN/segment pins.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range ≥ 2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; legal range 0 ≤ BLANK_CYCLES < REFRESH_DIV.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- d1..d8  in  6 each  glyph codes; d1 is the rightmost digit (an[0]), d8 the leftmost (an[7])
- an  out  8  digit anodes, active-low
- dec_cat  out  8  cathodes, active-low, {a,b,c,d,e,f,g,dp} with a = bit 7
- frame_start  out  1  one-cycle pulse at the start of each scan frame

Behaviour:
- Glyph code format {dash, val[3:0], dp}.
  - dash = 1: show only segment g; dp off; other bits ignored. 6'b111111 is the standard "-".
  - dash = 0: val selects the glyph; dp = 1 lights the decimal point.
- val glyph table, active-high abcdefg:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6/G = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - A (P) = 1100111, B (b) = 0011111, C (c) = 0001101, D (S) = 1011011, E (E) = 1001111, F (U) = 0111110
- dec_cat is the bitwise inverse of {abcdefg, dp}.
- State:
  - div_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - idx counts 0..7 and increments when div_cnt wraps.
  - idx 7 → 0 wraps.
- Slot phases, two states:
  - BLANK, while div_cnt < BLANK_CYCLES: an = 8'hFF, dec_cat = 8'hFF.
  - DRIVE, for the remaining cycles: an = ~(1 << idx); dec_cat is the decoded shadow[idx].
- Snapshot:
  - On the edge that enters slot 0 (div_cnt = 0, idx = 0), shadow[0..7] ← d1..d8.
  - frame_start is 1 in exactly that cycle and 0 otherwise.
  - Input changes at any other time take effect only at the next frame.
- Outputs are registered: an, dec_cat and frame_start change only on clock edges and are glitch-free.
- Reset (asynchronous, any time, including mid-slot or mid-frame):
  - an = 8'hFF, dec_cat = 8'hFF, frame_start = 0.
  - div_cnt = 0, idx = 0, all shadow registers = 6'b111111.
- After reset deasserts, the first edge is cycle 0 of slot 0:
  - snapshot is taken on that edge;
  - frame_start = 1 for that cycle;
  - slot 0 blanking begins.
- Frame period = 8 × REFRESH_DIV cycles.
- BLANK_CYCLES = 0: no blanking phase; DRIVE starts on the first cycle of the slot.
- Exactly one anode is low during DRIVE; no anode is low during BLANK.

Decomposition:
- Package bc_disp_pkg:
  - glyph code constants: GLY_DASH = 6'b111111, GLY_U, GLY_S, GLY_P, GLY_G, GLY_C, GLY_B, GLY_E, digit helper;
  - 7-bit segment pattern constants;
  - slot-phase enum {BLANK, DRIVE}.
- One combinational sub-module, bc_glyph_dec: 6-bit code in, 8-bit active-low cathode out. It is shared with any future single-digit display.

Test Plan (bench uses REFRESH_DIV = 8, BLANK_CYCLES = 2):
- Reset with d1..d8 = 6'b000010 ("1") → frame_start pulses on the first edge. Each slot is 2 cycles with an = FF, then 6 cycles with an[k] = 0 and dec_cat = 8'b10011111. Frame repeats every 64 cycles.
- d1 = U (6'b011110), d2 = S (6'b011010), d3 = 6'b111111, d4 = 6'b000010, d5 = P (6'b010100) → DRIVE dec_cat values are:
  - an[0]: 8'b10000011
  - an[1]: 8'b01001001
  - an[2]: 8'b11111101
  - an[3]: 8'b10011111
  - an[4]: 8'b00110001
- Change d1 from "1" to "2" while idx = 3 → an[0] keeps showing "1" until frame_start; the next frame shows 8'b00100101.
- d3 = 6'b000011 (1 with dp) → dec_cat = 8'b10011110 during slot 2.
- Assert reset at div_cnt = 5, idx = 4 → an = FF and dec_cat = FF immediately, without waiting for a clock edge. Shadows become dashes; after release the scan restarts at idx 0 with frame_start.
- Across a full 64-cycle frame, check every cycle: at most one an bit is low, and an = FF whenever div_cnt < 2.

Source files
------------

// File: rtl/bc_disp_pkg.sv
// bc_disp_pkg: shared types and constants for the 8-digit scanned display.
//   Glyph code format is {dash, val[3:0], dp}; segment patterns are active-high abcdefg.
//   Provides glyph code constants, segment constants, slot-phase enum, digit helper.
package bc_disp_pkg;

  // Active-high abcdefg segment patterns, a = bit 6.
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1100111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b0001101;
  localparam logic [6:0] SEG_D = 7'b1011011;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b0111110;
  localparam logic [6:0] SEG_G = 7'b0000001;  // middle bar only

  // Glyph codes for the letters the game uses (aliases of hex values).
  localparam logic [5:0] GLY_DASH = 6'b111111;
  localparam logic [5:0] GLY_U    = 6'b011110;  // val F
  localparam logic [5:0] GLY_S    = 6'b011010;  // val D
  localparam logic [5:0] GLY_P    = 6'b010100;  // val A
  localparam logic [5:0] GLY_G    = 6'b001100;  // val 6
  localparam logic [5:0] GLY_C    = 6'b011000;  // val C
  localparam logic [5:0] GLY_B    = 6'b010110;  // val B
  localparam logic [5:0] GLY_E    = 6'b011100;  // val E

  typedef enum logic {BLANK, DRIVE} phase_t;

  // Build a numeric glyph code from a 4-bit value and decimal-point flag.
  function automatic logic [5:0] glyph_digit(input logic [3:0] val, input logic dp);
    return {1'b0, val, dp};
  endfunction

endpackage

// File: rtl/bc_glyph_dec.sv
// bc_glyph_dec: combinational glyph-code to seven-segment cathode decoder.
//   Ports: code_i [5:0] glyph code {dash,val,dp}; cat_o [7:0] active-low {a..g,dp}.
//   Zero latency; no flow control.
module bc_glyph_dec
  import bc_disp_pkg::*;
(
  input  logic [5:0] code_i,
  output logic [7:0] cat_o
);

  logic [6:0] seg;
  logic       dp;

  always_comb begin
    seg = SEG_G;
    dp  = 1'b0;
    if (!code_i[5]) begin
      dp = code_i[0];
      case (code_i[4:1])
        4'h0: seg = SEG_0;
        4'h1: seg = SEG_1;
        4'h2: seg = SEG_2;
        4'h3: seg = SEG_3;
        4'h4: seg = SEG_4;
        4'h5: seg = SEG_5;
        4'h6: seg = SEG_6;
        4'h7: seg = SEG_7;
        4'h8: seg = SEG_8;
        4'h9: seg = SEG_9;
        4'hA: seg = SEG_A;
        4'hB: seg = SEG_B;
        4'hC: seg = SEG_C;
        4'hD: seg = SEG_D;
        4'hE: seg = SEG_E;
        default: seg = SEG_F;
      endcase
    end
  end

  assign cat_o = ~{seg, dp};

endmodule

// File: rtl/bc_disp_scan8.sv
// bc_disp_scan8: 8-digit common-anode scan driver with per-slot blanking and frame snapshot.
//   Ports: clock, reset (async high), d1..d8 glyph codes in; an, dec_cat (active-low),
//   frame_start pulse out. All outputs registered; one edge from position to pins.
module bc_disp_scan8
  import bc_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  output logic [7:0] an,
  output logic [7:0] dec_cat,
  output logic       frame_start
);

  localparam int              CW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(REFRESH_DIV - 1);

  // div_q/idx_q name the scan position that the next edge puts on the pins.
  logic [CW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic [5:0]    shadow_q [8];
  logic [5:0]    shadow_d [8];
  logic [5:0]    din      [8];
  logic [7:0]    an_q, dec_cat_q;
  logic          frame_start_q;
  logic          snap;
  logic          wrap;
  phase_t        phase;
  logic [7:0]    cat;

  assign din = '{d1, d2, d3, d4, d5, d6, d7, d8};

  always_comb begin
    snap  = (div_q == '0) && (idx_q == 3'd0);
    wrap  = (div_q == LAST);
    div_d = wrap ? '0 : div_q + 1'b1;
    idx_d = wrap ? idx_q + 3'd1 : idx_q;
    phase = (int'(div_q) < BLANK_CYCLES) ? BLANK : DRIVE;
    shadow_d = shadow_q;
    if (snap) shadow_d = din;
  end

  // Decode from the next-state shadow so that with no blanking the first
  // cycle of slot 0 already shows the freshly captured code.
  bc_glyph_dec u_dec (
    .code_i (shadow_d[idx_q]),
    .cat_o  (cat)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      idx_q         <= 3'd0;
      shadow_q      <= '{default: GLY_DASH};
      an_q          <= 8'hFF;
      dec_cat_q     <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      frame_start_q <= snap;
      if (phase == BLANK) begin
        an_q      <= 8'hFF;
        dec_cat_q <= 8'hFF;
      end else begin
        an_q      <= ~(8'd1 << idx_q);
        dec_cat_q <= cat;
      end
    end
  end

  assign an          = an_q;
  assign dec_cat     = dec_cat_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bc_disp_scan8.sv
module tb_bc_disp_scan8;

  localparam int RD = 8;
  localparam int BC = 2;

  localparam logic [5:0] G_ONE  = 6'b000010;
  localparam logic [5:0] G_TWO  = 6'b000100;
  localparam logic [5:0] G_ONEP = 6'b000011;
  localparam logic [5:0] G_U    = 6'b011110;
  localparam logic [5:0] G_S    = 6'b011010;
  localparam logic [5:0] G_DASH = 6'b111111;
  localparam logic [5:0] G_P    = 6'b010100;

  localparam logic [7:0] C_1  = 8'b10011111;
  localparam logic [7:0] C_1P = 8'b10011110;
  localparam logic [7:0] C_2  = 8'b00100101;
  localparam logic [7:0] C_U  = 8'b10000011;
  localparam logic [7:0] C_S  = 8'b01001001;
  localparam logic [7:0] C_D  = 8'b11111101;
  localparam logic [7:0] C_P  = 8'b00110001;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] dv [8];
  logic [7:0] an, dec_cat;
  logic       frame_start;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  bc_disp_scan8 #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clock       (clock),
    .reset       (reset),
    .d1          (dv[0]),
    .d2          (dv[1]),
    .d3          (dv[2]),
    .d4          (dv[3]),
    .d5          (dv[4]),
    .d6          (dv[5]),
    .d7          (dv[6]),
    .d8          (dv[7]),
    .an          (an),
    .dec_cat     (dec_cat),
    .frame_start (frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Runs ncyc cycles starting at frame position 0, checking every cycle.
  // exp holds the expected DRIVE cathodes, slot k at exp[8k +: 8].
  // At cycle chg_cyc (if >= 0) d1 is changed to chg_val.
  task automatic run_frame(input logic [63:0] exp, input int ncyc,
                           input int chg_cyc, input logic [5:0] chg_val);
    for (int n = 0; n < ncyc; n++) begin
      int c, k;
      logic [7:0] e_an, e_cat;
      @(posedge clock);
      @(negedge clock);
      c = n % RD;
      k = (n / RD) % 8;
      e_an  = (c < BC) ? 8'hFF : ~(8'd1 << k);
      e_cat = (c < BC) ? 8'hFF : exp[8*k +: 8];
      chk($sformatf("frame_start n=%0d", n), {31'd0, frame_start}, {31'd0, (n % 64) == 0});
      chk($sformatf("an n=%0d", n), {24'd0, an}, {24'd0, e_an});
      chk($sformatf("dec_cat n=%0d", n), {24'd0, dec_cat}, {24'd0, e_cat});
      chk($sformatf("one_hot n=%0d", n), {31'd0, $countones(~an) <= 1}, 32'd1);
      if (n == chg_cyc) dv[0] = chg_val;
    end
  endtask

  initial begin
    logic [63:0] e_fr;
    for (int i = 0; i < 8; i++) dv[i] = G_ONE;

    // Reset state
    #12;
    chk("rst an", {24'd0, an}, 32'h0000_00FF);
    chk("rst cat", {24'd0, dec_cat}, 32'h0000_00FF);
    chk("rst fs", {31'd0, frame_start}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // All "1", two frames back to back to show the 64-cycle repeat
    e_fr = {8{C_1}};
    run_frame(e_fr, 64, -1, G_ONE);
    run_frame(e_fr, 64, -1, G_ONE);

    // Letters and dash
    dv[0] = G_U; dv[1] = G_S; dv[2] = G_DASH; dv[3] = G_ONE; dv[4] = G_P;
    e_fr = {C_1, C_1, C_1, C_P, C_1, C_D, C_S, C_U};
    run_frame(e_fr, 64, -1, G_ONE);

    // d1 changes mid-frame (slot 3); only visible from the next frame on
    dv[0] = G_ONE; dv[2] = G_ONEP;
    e_fr = {C_1, C_1, C_1, C_P, C_1, C_1P, C_S, C_1};
    run_frame(e_fr, 64, 24, G_TWO);
    e_fr = {C_1, C_1, C_1, C_P, C_1, C_1P, C_S, C_2};
    run_frame(e_fr, 64, -1, G_TWO);

    // Stop at position div=5, idx=4, then reset asynchronously mid-cycle
    run_frame(e_fr, 38, -1, G_TWO);
    #1 reset = 1'b1;
    #1;
    chk("async rst an", {24'd0, an}, 32'h0000_00FF);
    chk("async rst cat", {24'd0, dec_cat}, 32'h0000_00FF);
    chk("async rst fs", {31'd0, frame_start}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    run_frame(e_fr, 64, -1, G_TWO);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
